// File: rtl/mult_issue_pipe.sv
// mult_issue_pipe: credit-limited RV32M multiply unit feeding the CDB.
// Define MULT_ISSUE_HIGH_EN for MULH/MULHSU/MULHU; otherwise every op is MUL.
module mult_issue_pipe #(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 6,
  parameter int LATENCY   = 4,
  parameter int OUT_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_queue_rdy,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [TAG_W-1:0] rd_tag,
  input  logic [1:0]       op,
  input  logic             flush,
  input  logic             cdb_grant,
  output logic             read_enable,
  output logic             cdb_valid,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [XLEN-1:0]  cdb_result,
  output logic             cdb_branch,
  output logic             issue_done
);

  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    occ;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [XLEN-1:0]  res_mem [OUT_DEPTH];
  logic [TAG_W-1:0] tag_mem [OUT_DEPTH];

  logic             issue;
  logic             pop;
  logic             has_head;
  logic             wr_en;
  logic [XLEN-1:0]  s0_res;
  logic [XLEN-1:0]  wr_res;
  logic [TAG_W-1:0] wr_tag;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign read_enable = rst_n & issue_queue_rdy & ~flush
                     & (cnt < CW'(OUT_DEPTH));
  assign issue       = read_enable;

  assign has_head    = (occ != '0);
  assign cdb_valid   = has_head & ~flush;
  assign cdb_tag     = has_head ? tag_mem[rd_ptr] : '0;
  assign cdb_result  = has_head ? res_mem[rd_ptr] : '0;
  assign cdb_branch  = 1'b0;

  assign pop         = cdb_valid & cdb_grant;
  assign issue_done  = pop;

`ifdef MULT_ISSUE_HIGH_EN
  logic              sa;
  logic              sb;
  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] b_ext;
  logic [2*XLEN-1:0] prod;

  // Product of the (XLEN+1)-bit extended operands, kept mod 2^(2*XLEN).
  assign sa     = ((op == 2'b01) | (op == 2'b10)) & rs1_data[XLEN-1];
  assign sb     = (op == 2'b01) & rs2_data[XLEN-1];
  assign a_ext  = {{XLEN{sa}}, rs1_data};
  assign b_ext  = {{XLEN{sb}}, rs2_data};
  assign prod   = a_ext * b_ext;
  assign s0_res = (op == 2'b00) ? prod[XLEN-1:0]
                                : prod[2*XLEN-1:XLEN];
`else
  logic [1:0] unused_op;

  assign unused_op = op;
  assign s0_res    = rs1_data * rs2_data;
`endif

  generate
    if (LATENCY == 1) begin : g_direct
      assign wr_en  = issue;
      assign wr_res = s0_res;
      assign wr_tag = rd_tag;
    end else begin : g_pipe
      logic [LATENCY-2:0] v;
      logic [XLEN-1:0]    r [LATENCY-1];
      logic [TAG_W-1:0]   t [LATENCY-1];

      always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
          v <= '0;
        end else begin
          v[0] <= issue;
          for (int i = 1; i < LATENCY - 1; i++)
            v[i] <= v[i-1];
        end
      end

      always_ff @(posedge clk) begin
        r[0] <= s0_res;
        t[0] <= rd_tag;
        for (int i = 1; i < LATENCY - 1; i++) begin
          r[i] <= r[i-1];
          t[i] <= t[i-1];
        end
      end

      assign wr_en  = v[LATENCY-2];
      assign wr_res = r[LATENCY-2];
      assign wr_tag = t[LATENCY-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      cnt    <= '0;
      occ    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= nxt(wr_ptr);
      if (pop)
        rd_ptr <= nxt(rd_ptr);
      occ <= occ + CW'(wr_en) - CW'(pop);
      cnt <= cnt + CW'(issue) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      res_mem[wr_ptr] <= wr_res;
      tag_mem[wr_ptr] <= wr_tag;
    end
  end

  // A full buffer may only be written in a cycle that also pops.
  assert property (@(posedge clk) disable iff (!rst_n || flush)
    !(wr_en && !pop && occ == CW'(OUT_DEPTH)));

endmodule

// File: tb/tb_mult_issue_pipe.sv
// tb_mult_issue_pipe: random and directed checks of mult_issue_pipe
// against a queue-based reference model.
module tb_mult_issue_pipe;

  localparam int LAT   = 4;
  localparam int DEPTH = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [5:0]  tag = '0;
  logic [1:0]  op = '0;
  logic        flush = 1'b0;
  logic        grant = 1'b1;
  logic        read_enable;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_result;
  logic        cdb_branch;
  logic        issue_done;

  mult_issue_pipe #(
    .XLEN(32), .TAG_W(6), .LATENCY(LAT), .OUT_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .issue_queue_rdy(rdy),
    .rs1_data(a), .rs2_data(b), .rd_tag(tag), .op(op),
    .flush(flush), .cdb_grant(grant),
    .read_enable(read_enable), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_result(cdb_result),
    .cdb_branch(cdb_branch), .issue_done(issue_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int re_cnt = 0;
  int done_cnt = 0;

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] res;
    int          due;
  } ent_t;

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] res;
    int          at;
  } done_t;

  ent_t  q[$];
  done_t seen[$];
  int    iss_at[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic [1:0]  o);
`ifdef MULT_ISSUE_HIGH_EN
    longint      sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    case (o)
      2'b01:   p = sx * sy;
      2'b10:   p = sx * uy;
      2'b11:   p = ux * uy;
      default: return x * y;
    endcase
    return p[63:32];
`else
    return x * y;
`endif
  endfunction

  always @(negedge clk) begin : cmp
    bit ev, ere, ed;
    if (read_enable) begin
      re_cnt++;
      iss_at.push_back(cyc);
    end
    if (issue_done) begin
      done_cnt++;
      seen.push_back('{cdb_tag, cdb_result, cyc});
    end
    if (!rst_n) begin
      chk("re_in_reset", longint'(read_enable), 0);
      q.delete();
    end else begin
      ere = rdy && !flush && (q.size() < DEPTH);
      ev  = !flush && (q.size() > 0) && (q[0].due <= cyc);
      ed  = ev && grant;
      chk("read_enable", longint'(read_enable), longint'(ere));
      chk("cdb_valid", longint'(cdb_valid), longint'(ev));
      chk("issue_done", longint'(issue_done), longint'(ed));
      chk("cdb_branch", longint'(cdb_branch), 0);
      if (ev) begin
        chk("cdb_tag", longint'(cdb_tag), longint'(q[0].tag));
        chk("cdb_result", longint'(cdb_result), longint'(q[0].res));
      end
      if (flush) begin
        q.delete();
      end else begin
        if (ed) void'(q.pop_front());
        if (ere) q.push_back('{tag, ref_mul(a, b, op), cyc + LAT});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input logic [31:0] x,
                       input logic [31:0] y, input logic [5:0] t,
                       input logic [1:0] o);
    rdy = r; a = x; b = y; tag = t; op = o;
  endtask

  task automatic chk_zero(input string nm);
    #1;
    chk({nm, "_re"}, longint'(read_enable), 0);
    chk({nm, "_valid"}, longint'(cdb_valid), 0);
    chk({nm, "_tag"}, longint'(cdb_tag), 0);
    chk({nm, "_res"}, longint'(cdb_result), 0);
    chk({nm, "_branch"}, longint'(cdb_branch), 0);
    chk({nm, "_done"}, longint'(issue_done), 0);
  endtask

  logic [31:0] hi_exp [4];
  logic [31:0] pick [5];

  initial begin
    int m, ib, rb, db, bad;
`ifdef MULT_ISSUE_HIGH_EN
    hi_exp = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE};
`else
    hi_exp = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE};
`endif
    pick = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1};

    repeat (2) step();
    rst_n = 1'b1;
    chk_zero("reset");

    // Single MUL 7*6.
    m = seen.size();
    ib = iss_at.size();
    drive(1, 7, 6, 3, 2'b00);
    step();
    rdy = 1'b0;
    repeat (8) step();
    chk("s1_issues", iss_at.size() - ib, 1);
    chk("s1_dones", seen.size() - m, 1);
    chk("s1_tag", longint'(seen[m].tag), 3);
    chk("s1_res", longint'(seen[m].res), 42);
    chk("s1_latency", seen[m].at - iss_at[ib], LAT);

    // High-half variants.
    m = seen.size();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'hFFFFFFFF, 2, 6'(10 + i), 2'((i + 1) % 4));
      step();
    end
    rdy = 1'b0;
    repeat (8) step();
    chk("hi_dones", seen.size() - m, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("hi_res%0d", i), longint'(seen[m+i].res),
          longint'(hi_exp[i]));

    // Back-pressure: credits stop issue with the CDB stalled.
    grant = 1'b0;
    rb = re_cnt;
    for (int i = 0; i < 12; i++) begin
      drive(1, $urandom, $urandom, 6'(20 + i), 2'($urandom));
      step();
    end
    chk("bp_issues", re_cnt - rb, DEPTH);
    chk("bp_re_low", longint'(read_enable), 0);
    m = seen.size();
    ib = iss_at.size();
    grant = 1'b1;
    repeat (3) step();
    chk("bp_resume", iss_at[ib] - seen[m].at, 1);
    rdy = 1'b0;
    repeat (15) step();

    // Streaming 20 back-to-back ops.
    rb = re_cnt;
    db = done_cnt;
    m = seen.size();
    for (int i = 0; i < 20; i++) begin
      drive(1, $urandom, $urandom, 6'(i), 2'($urandom));
      step();
    end
    rdy = 1'b0;
    chk("st_issues", re_cnt - rb, 20);
    repeat (10) step();
    chk("st_dones", done_cnt - db, 20);
    bad = 0;
    for (int i = 0; i < 20; i++)
      if (seen[m+i].tag != 6'(i)) bad++;
    chk("st_order", bad, 0);

    // Flush: one buffered, two in the pipe.
    grant = 1'b0;
    drive(1, 3, 5, 40, 2'b00);
    step();
    rdy = 1'b0;
    step();
    drive(1, 4, 5, 41, 2'b00);
    step();
    drive(1, 5, 5, 42, 2'b00);
    step();
    drive(1, 6, 5, 43, 2'b00);
    flush = 1'b1;
    grant = 1'b1;
    #1;
    chk("fl_valid", longint'(cdb_valid), 0);
    chk("fl_re", longint'(read_enable), 0);
    chk("fl_done", longint'(issue_done), 0);
    step();
    flush = 1'b0;
    m = seen.size();
    ib = iss_at.size();
    drive(1, 9, 9, 44, 2'b00);
    step();
    rdy = 1'b0;
    repeat (8) step();
    chk("fl_dones", seen.size() - m, 1);
    chk("fl_new_tag", longint'(seen[m].tag), 44);
    chk("fl_new_res", longint'(seen[m].res), 81);
    chk("fl_latency", seen[m].at - iss_at[ib], LAT);
    bad = 0;
    foreach (seen[i])
      if (seen[i].tag >= 40 && seen[i].tag <= 43) bad++;
    chk("fl_no_stale", bad, 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      rdy   = ($urandom % 4) != 0;
      grant = ($urandom % 3) != 0;
      flush = ($urandom % 50) == 0;
      a     = ($urandom % 3 == 0) ? pick[$urandom % 5] : $urandom;
      b     = ($urandom % 3 == 0) ? pick[$urandom % 5] : $urandom;
      tag   = 6'($urandom);
      op    = 2'($urandom);
      step();
    end
    flush = 1'b0;
    rdy = 1'b0;
    grant = 1'b1;
    repeat (12) step();

    // Reset mid-stream.
    for (int i = 0; i < 10; i++) begin
      drive(1, $urandom, $urandom, 6'(16 + i), 2'($urandom));
      grant = (i % 3) != 0;
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rdy = 1'b0;
    grant = 1'b1;
    chk_zero("mid_reset");
    m = seen.size();
    for (int i = 0; i < 8; i++) begin
      drive(1, $urandom, $urandom, 6'(48 + i), 2'($urandom));
      step();
    end
    rdy = 1'b0;
    repeat (10) step();
    chk("rst_dones", seen.size() - m, 8);
    bad = 0;
    for (int i = m; i < seen.size(); i++)
      if (seen[i].tag < 48) bad++;
    chk("rst_no_stale", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_issue_pipe.md
# mult_issue_pipe

Parametrised, back-pressured multiply execution unit between the multiply issue queue and the common data bus (CDB). It accepts one operation per cycle and supports the RV32M multiply variants (MUL, MULH, MULHSU, MULHU). Results pass through a configurable-latency pipeline into an output buffer that holds them until the CDB arbiter grants. Issue is credit-limited, so in-flight results never overflow the buffer, and a flush input discards all pending work on a branch mispredict.

## Interface
- XLEN, 32, operand/result width
- TAG_W, 6, ROB/rename tag width
- LATENCY, 4, pipeline stages from issue to buffer write; legal range ≥1
- OUT_DEPTH, 2, output buffer entries; legal range ≥1; also the credit limit

- clk  in  1  clock; single clock domain, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- issue_queue_rdy  in  1  issue queue head holds a valid operation
- rs1_data  in  XLEN  operand A
- rs2_data  in  XLEN  operand B
- rd_tag  in  TAG_W  destination tag
- op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- flush  in  1  kill all in-flight and buffered results
- cdb_grant  in  1  CDB arbiter accepts the current head this cycle
- read_enable  out  1  pops the issue queue; operands are sampled this cycle
- cdb_valid  out  1  buffer head valid, requesting the CDB
- cdb_tag  out  TAG_W  head tag
- cdb_result  out  XLEN  head result
- cdb_branch  out  1  constant 0
- issue_done  out  1  one-cycle pulse when the CDB accepts a result

## Operation
- Credit counter `cnt` (0..OUT_DEPTH) counts operations issued but not yet accepted by the CDB.
  - `read_enable = issue_queue_rdy & ~flush & (cnt < OUT_DEPTH)`.
- Operation accepted in cycle T (read_enable=1):
  - 2·XLEN-bit product is formed from (XLEN+1)-bit extended operands.
    - MULH: both operands sign-extended.
    - MULHSU: rs1 sign-extended, rs2 zero-extended.
    - MULHU and MUL: both operands zero-extended.
  - MUL selects bits [XLEN-1:0]; all other ops select [2XLEN-1:XLEN].
  - Computed value and tag enter stage 0 with valid=1.
  - An idle cycle inserts valid=0; the pipeline advances unconditionally.
- Stage LATENCY-1 writes into the circular output buffer when valid.
  - Credits guarantee the buffer is never written while full; this is asserted in simulation.
- Buffer head drives cdb_valid/cdb_tag/cdb_result; cdb_valid is masked by ~flush.
- Pop on `cdb_valid & cdb_grant`: issue_done=1 that cycle, head pointer advances, cnt decrements.
- Counter update rules:
  - Issue and pop in the same cycle: cnt unchanged.
  - Buffer write and pop in the same cycle: both are allowed, including at full (pop frees the slot first) or empty (a write to an empty buffer is not visible until the next cycle).
- flush=1:
  - read_enable=0, cdb_valid=0, issue_done=0.
  - Next edge: all pipeline valids cleared, buffer pointers and cnt reset to 0, grant ignored.
- Pointer wrap: modulo OUT_DEPTH; a separate occupancy count handles non-power-of-two depths.

## Timing
- Reset (rst_n=0 at an edge):
  - Pipeline valids, pointers and cnt go to 0.
  - Outputs: read_enable=0, cdb_valid=0, cdb_tag=0, cdb_result=0, cdb_branch=0, issue_done=0.
  - Reset mid-operation discards everything, same as flush.
- Latency: issued in cycle T, visible on cdb_valid in cycle T+LATENCY (earliest grant cycle) when the buffer is empty.
- Throughput: 1 op/cycle while the CDB grants every cycle and OUT_DEPTH ≥ LATENCY+1; otherwise bounded by credits.
- Outputs read_enable and cdb_valid are combinational from registered state plus issue_queue_rdy/flush; no combinational path from cdb_grant to read_enable.

## Configuration
- MULT_ISSUE_HIGH_EN defined: all four ops as described.
- Undefined:
  - op is ignored and every operation behaves as MUL, using an XLEN×XLEN multiplier producing the low half only.
  - No other change in interface or timing.

## Test plan
- Single MUL, LATENCY=4, rs1=7, rs2=6, tag=3, grant held 1 -> cdb_valid at T+4 with result 42, tag 3; issue_done pulses once.
- High variants, rs1=0xFFFFFFFF, rs2=2 -> MULH 0xFFFFFFFF, MULHSU 0xFFFFFFFF, MULHU 0x00000001, MUL 0xFFFFFFFE (with MULT_ISSUE_HIGH_EN; without it, all four give 0xFFFFFFFE).
- Back-pressure, OUT_DEPTH=2, grant=0, issue_queue_rdy held -> exactly 2 read_enable pulses, then read_enable=0. Releasing grant -> results drain in order; read_enable resumes the cycle after the first pop.
- Streaming, OUT_DEPTH=5, grant=1 every cycle, 20 back-to-back ops -> read_enable never drops, 20 issue_done pulses, tags in issue order.
- Flush with 2 ops in the pipeline and 1 buffered -> cdb_valid=0 in the flush cycle, cnt=0 after it, none of the 3 tags ever appear, and a new op issued the next cycle returns after LATENCY cycles.
- rst_n low for 1 cycle mid-stream -> all outputs 0, no stale tag emitted afterward.
